// File: rtl/q_ingress_arb_if.sv
// Ingress-side bundle of q_ingress_arb: per-source beat handshake, control inputs and
// the registered beat/status outputs toward the q block.
interface q_ingress_arb_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] i_src_vld;
  logic [N-1:0] i_src_sop;
  logic [N-1:0] i_src_eop;
  logic [N-1:0] o_src_rdy;
  logic         i_stall;
  logic         i_err_clr;
  logic         o_ingress_vld_r;
  logic         o_ingress_sop_r;
  logic         o_ingress_eop_r;
  logic [N-1:0] o_err_r;
  logic [31:0]  o_pkt_cnt_r;

  modport master (
    output i_src_vld, i_src_sop, i_src_eop, i_stall, i_err_clr,
    input  o_src_rdy, o_ingress_vld_r, o_ingress_sop_r, o_ingress_eop_r, o_err_r, o_pkt_cnt_r
  );

  modport slave (
    input  i_src_vld, i_src_sop, i_src_eop, i_stall, i_err_clr,
    output o_src_rdy, o_ingress_vld_r, o_ingress_sop_r, o_ingress_eop_r, o_err_r, o_pkt_cnt_r
  );
endinterface

// File: rtl/q_ingress_arb.sv
// Packet-atomic round-robin arbiter feeding the q ingress port through one register stage,
// with framing / max-length policing and sticky per-source error flags.
module q_ingress_arb #(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BEATS = 64
) (
  input logic            clk,
  input logic            arst,
  q_ingress_arb_if.slave bus
);
  localparam int unsigned PtrW = $clog2(N);
  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {StIdle, StPkt, StDrain} state_e;

  state_e          r_state, w_state_d;
  logic [PtrW-1:0] r_owner, w_owner_d;
  logic [PtrW-1:0] r_ptr, w_ptr_d;
  logic [CntW-1:0] r_beats, w_beats_d;
  logic            r_vld, r_sop, r_eop;
  logic            w_vld, w_sop, w_eop;
  logic [N-1:0]    r_err, w_err_set, w_rdy, w_cand;
  logic [31:0]     r_pkt_cnt;
  logic            w_pkt_inc;
  logic            w_found;
  logic [PtrW-1:0] w_win;

  function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] idx);
    return (idx == PtrW'(N - 1)) ? '0 : idx + PtrW'(1);
  endfunction

  assign w_cand = bus.i_src_vld & bus.i_src_sop & {N{~bus.i_stall}};

  // First candidate at or after the pointer, wrapping modulo N (N need not be a power of 2).
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_win   = r_ptr;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && w_cand[idx]) begin
        w_found = 1'b1;
        w_win   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_ptr_d   = r_ptr;
    w_beats_d = r_beats;
    w_rdy     = '0;
    w_vld     = 1'b0;
    w_sop     = 1'b0;
    w_eop     = 1'b0;
    w_pkt_inc = 1'b0;
    w_err_set = '0;
    unique case (r_state)
      StIdle: begin
        w_err_set = bus.i_src_vld & ~bus.i_src_sop;
        if (w_found) begin
          w_rdy[w_win] = 1'b1;
          w_vld        = 1'b1;
          w_sop        = 1'b1;
          w_eop        = bus.i_src_eop[w_win];
          if (bus.i_src_eop[w_win]) begin
            w_ptr_d   = next_idx(w_win);
            w_pkt_inc = 1'b1;
          end else begin
            w_state_d = StPkt;
            w_owner_d = w_win;
            w_beats_d = CntW'(1);
          end
        end
      end
      StPkt: begin
        w_rdy[r_owner] = ~bus.i_stall;
        if (bus.i_src_vld[r_owner] && !bus.i_stall) begin
          w_vld              = 1'b1;
          w_eop              = bus.i_src_eop[r_owner];
          w_beats_d          = r_beats + CntW'(1);
          w_err_set[r_owner] = bus.i_src_sop[r_owner];
          if (bus.i_src_eop[r_owner]) begin
            w_state_d = StIdle;
            w_ptr_d   = next_idx(r_owner);
            w_pkt_inc = 1'b1;
            w_beats_d = '0;
          end else if (r_beats == CntW'(MAX_BEATS - 1)) begin
            // Truncate: close the packet downstream, then swallow the rest of it.
            w_eop              = 1'b1;
            w_pkt_inc          = 1'b1;
            w_err_set[r_owner] = 1'b1;
            w_state_d          = StDrain;
          end
        end
      end
      StDrain: begin
        w_rdy[r_owner] = 1'b1;
        if (bus.i_src_vld[r_owner] && bus.i_src_eop[r_owner]) begin
          w_state_d = StIdle;
          w_ptr_d   = next_idx(r_owner);
          w_beats_d = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= StIdle;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_beats   <= '0;
      r_vld     <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_err     <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_ptr   <= w_ptr_d;
      r_beats <= w_beats_d;
      r_vld   <= w_vld;
      r_sop   <= w_sop;
      r_eop   <= w_eop;
      r_err   <= (bus.i_err_clr ? '0 : r_err) | w_err_set;
      if (w_pkt_inc) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end

  assign bus.o_src_rdy       = w_rdy;
  assign bus.o_ingress_vld_r = r_vld;
  assign bus.o_ingress_sop_r = r_sop;
  assign bus.o_ingress_eop_r = r_eop;
  assign bus.o_err_r         = r_err;
  assign bus.o_pkt_cnt_r     = r_pkt_cnt;
endmodule
